// File: rtl/switch_debounce_3ch.sv
// Synchroniser, per-channel debounce FSM and post-reset init window for slide switches.
// Optional macro SW_TGL_CNT_EN adds an 8-bit toggle-event counter output tgl_cnt.
module switch_debounce_3ch #(
  parameter int          N_CH    = 3,
  parameter int          DB_BITS = 20,
  parameter int unsigned DB_MAX  = 999_999
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] sw_tgl,
  output logic            any_tgl,
  output logic            sw_par,
`ifdef SW_TGL_CNT_EN
  output logic [7:0]      tgl_cnt,
`endif
  output logic            ready
);

  localparam logic [DB_BITS-1:0] L_DB_MAX    = DB_BITS'(DB_MAX);
  // Init counter is one bit wider so DB_MAX+3 never overflows it.
  localparam logic [DB_BITS:0]   L_INIT_LAST = (DB_BITS+1)'(DB_MAX + 3);

  typedef enum logic {ST_STABLE = 1'b0, ST_CHECK = 1'b1} state_t;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] r_db;
  logic [N_CH-1:0] r_tgl;
  logic            r_any_tgl;
  logic            r_par;
  logic            r_ready;
  logic [DB_BITS:0] r_init_cnt;

  logic [N_CH-1:0] w_db_next;
  logic [N_CH-1:0] w_evt;
  logic [N_CH-1:0] w_tgl_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t             r_state;
      state_t             w_state_next;
      logic [DB_BITS-1:0] r_cnt;
      logic [DB_BITS-1:0] w_cnt_next;
      logic               w_db_nx;
      logic               w_evt_l;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_STABLE: if (r_sync2[gi] != r_db[gi]) w_state_next = ST_CHECK;
          ST_CHECK:  if ((r_sync2[gi] == r_db[gi]) || (r_cnt == L_DB_MAX))
                       w_state_next = ST_STABLE;
          default:   w_state_next = ST_STABLE;
        endcase
      end

      always_comb begin
        w_cnt_next = r_cnt;
        w_db_nx    = r_db[gi];
        w_evt_l    = 1'b0;
        case (r_state)
          ST_STABLE: if (r_sync2[gi] != r_db[gi]) w_cnt_next = '0;
          ST_CHECK: begin
            if (r_sync2[gi] == r_db[gi]) begin
              w_cnt_next = '0;
            end else if (r_cnt == L_DB_MAX) begin
              w_cnt_next = '0;
              w_db_nx    = r_sync2[gi];
              w_evt_l    = 1'b1;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          default: w_cnt_next = '0;
        endcase
      end

      assign w_db_next[gi] = w_db_nx;
      assign w_evt[gi]     = w_evt_l;
    end
  endgenerate

  // Toggles qualified during the init window load sw_db silently.
  assign w_tgl_next = w_evt & {N_CH{r_ready}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_db       <= '0;
      r_tgl      <= '0;
      r_any_tgl  <= 1'b0;
      r_par      <= 1'b0;
      r_ready    <= 1'b0;
      r_init_cnt <= '0;
    end else begin
      r_sync1   <= sw_raw;
      r_sync2   <= r_sync1;
      r_db      <= w_db_next;
      r_tgl     <= w_tgl_next;
      r_any_tgl <= |w_tgl_next;
      r_par     <= ^w_db_next;
      if (!r_ready) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == L_INIT_LAST) r_ready <= 1'b1;
      end
    end
  end

`ifdef SW_TGL_CNT_EN
  logic [7:0] r_tgl_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tgl_cnt <= 8'd0;
    else if (r_any_tgl) r_tgl_cnt <= r_tgl_cnt + 8'd1;
  end

  assign tgl_cnt = r_tgl_cnt;
`endif

  assign sw_db   = r_db;
  assign sw_tgl  = r_tgl;
  assign any_tgl = r_any_tgl;
  assign sw_par  = r_par;
  assign ready   = r_ready;

endmodule

// File: tb/tb_switch_debounce_3ch.sv
// Directed bench for switch_debounce_3ch with DB_MAX=4 (7-edge latency, ready on edge 8).
module tb_switch_debounce_3ch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw_raw = 3'b000;
  logic [2:0] sw_db;
  logic [2:0] sw_tgl;
  logic       any_tgl;
  logic       sw_par;
  logic       ready;
`ifdef SW_TGL_CNT_EN
  logic [7:0] tgl_cnt;
  int         exp_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  switch_debounce_3ch #(.N_CH(3), .DB_BITS(3), .DB_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_db   (sw_db),
    .sw_tgl  (sw_tgl),
    .any_tgl (any_tgl),
    .sw_par  (sw_par),
`ifdef SW_TGL_CNT_EN
    .tgl_cnt (tgl_cnt),
`endif
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_db"},    {5'd0, sw_db}, 8'd0);
    chk({tag, "_tgl"},   {5'd0, sw_tgl}, 8'd0);
    chk({tag, "_any"},   {7'd0, any_tgl}, 8'd0);
    chk({tag, "_par"},   {7'd0, sw_par}, 8'd0);
    chk({tag, "_ready"}, {7'd0, ready}, 8'd0);
  endtask

  // Apply a new raw level; the next edge samples it, sw_db moves 7 edges later.
  task automatic qualify(input string tag, input logic [2:0] raw,
                         input logic [2:0] old_db, input logic [2:0] new_db,
                         input logic [2:0] exp_tgl);
    sw_raw = raw;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk({tag, "_hold_db"},  {5'd0, sw_db}, {5'd0, old_db});
      chk({tag, "_hold_tgl"}, {5'd0, sw_tgl}, 8'd0);
    end
    tick();
    chk({tag, "_db"},  {5'd0, sw_db}, {5'd0, new_db});
    chk({tag, "_tgl"}, {5'd0, sw_tgl}, {5'd0, exp_tgl});
    chk({tag, "_any"}, {7'd0, any_tgl}, 8'd1);
    chk({tag, "_par"}, {7'd0, sw_par}, {7'd0, ^new_db});
    tick();
    chk({tag, "_tgl_clr"}, {5'd0, sw_tgl}, 8'd0);
    chk({tag, "_any_clr"}, {7'd0, any_tgl}, 8'd0);
    $display("txn %s: raw=%b db %b->%b tgl=%b", tag, raw, old_db, new_db, exp_tgl);
`ifdef SW_TGL_CNT_EN
    exp_cnt = (exp_cnt + 1) % 256;
    chk({tag, "_cnt"}, tgl_cnt, 8'(exp_cnt));
`endif
  endtask

  initial begin
    // 1: reset with all switches low
    rst_n  = 1'b0;
    sw_raw = 3'b000;
    tick();
    tick();
    chk_idle_outputs("t1_rst");
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t1_ready", {7'd0, ready}, (k >= 8) ? 8'd1 : 8'd0);
      chk("t1_db",    {5'd0, sw_db}, 8'd0);
      chk("t1_tgl",   {5'd0, sw_tgl}, 8'd0);
      chk("t1_any",   {7'd0, any_tgl}, 8'd0);
    end
    $display("txn t1: quiet reset, ready=%b sw_db=%b", ready, sw_db);

    // 2: reset with 101 held; loads silently during the init window
    rst_n  = 1'b0;
    sw_raw = 3'b101;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t2_tgl",   {5'd0, sw_tgl}, 8'd0);
      chk("t2_any",   {7'd0, any_tgl}, 8'd0);
      chk("t2_ready", {7'd0, ready}, (k >= 8) ? 8'd1 : 8'd0);
      if (k >= 8) begin
        chk("t2_db",  {5'd0, sw_db}, 8'b101);
        chk("t2_par", {7'd0, sw_par}, 8'd0);
      end
    end
    $display("txn t2: power-up high, sw_db=%b sw_par=%b", sw_db, sw_par);

    // 3: after ready, channel 0 rises
    rst_n  = 1'b0;
    sw_raw = 3'b000;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    chk("t3_ready", {7'd0, ready}, 8'd1);
    qualify("t3", 3'b001, 3'b000, 3'b001, 3'b001);

    // 4: 3-cycle glitch on channel 1 is rejected
    sw_raw = 3'b011;
    for (int k = 0; k < 3; k++) tick();
    sw_raw = 3'b001;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t4_glitch_db",  {5'd0, sw_db}, 8'b001);
      chk("t4_glitch_tgl", {5'd0, sw_tgl}, 8'd0);
      chk("t4_glitch_any", {7'd0, any_tgl}, 8'd0);
    end
    $display("txn t4_glitch: sw_db=%b unchanged", sw_db);
    // bounce 1/0 then steady 1: latency counts from the last 0->1 sample
    sw_raw = 3'b011;
    tick();
    sw_raw = 3'b001;
    tick();
    qualify("t4_bounce", 3'b011, 3'b001, 3'b011, 3'b010);

    // 5: channels 0 and 2 change on the same edge
    qualify("t5", 3'b110, 3'b011, 3'b110, 3'b101);
`ifdef SW_TGL_CNT_EN
    for (int n = 0; n < 253; n++) begin
      sw_raw = sw_raw ^ 3'b001;
      for (int k = 0; k < 9; k++) tick();
      exp_cnt = (exp_cnt + 1) % 256;
    end
    chk("t5_cnt_wrap", tgl_cnt, 8'(exp_cnt));
    chk("t5_cnt_zero", tgl_cnt, 8'd0);
    $display("txn t5_wrap: tgl_cnt=%0d", tgl_cnt);
    sw_raw = 3'b110;
    for (int k = 0; k < 9; k++) tick();
`endif

    // 6: reset while channel 0 is mid-qualification (cnt=2)
    sw_raw = 3'b111;
    for (int k = 0; k < 5; k++) tick();
    chk("t6_pre_db", {5'd0, sw_db}, 8'b110);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_async");
`ifdef SW_TGL_CNT_EN
    chk("t6_cnt", tgl_cnt, 8'd0);
`endif
    tick();
    tick();
    chk_idle_outputs("t6_held");
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t6_ready", {7'd0, ready}, (k >= 8) ? 8'd1 : 8'd0);
      chk("t6_tgl",   {5'd0, sw_tgl}, 8'd0);
      if (k >= 8) begin
        chk("t6_db",  {5'd0, sw_db}, 8'b111);
        chk("t6_par", {7'd0, sw_par}, 8'd1);
      end
    end
    $display("txn t6: reset mid-check, sw_db=%b ready=%b", sw_db, ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
